// File: rtl/moter_pkg.sv
// Shared motor select definitions: speed levels, select codes and level-to-select mapping.
package moter_pkg;

    localparam int unsigned LVL_W = 3;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned PWM_W = 5;

    localparam logic [LVL_W-1:0] LVL_STOP = 3'd0;
    localparam logic [LVL_W-1:0] LVL_1    = 3'd1;
    localparam logic [LVL_W-1:0] LVL_2    = 3'd2;
    localparam logic [LVL_W-1:0] LVL_3    = 3'd3;
    localparam logic [LVL_W-1:0] LVL_4    = 3'd4;

    localparam logic [SEL_W-1:0] SEL_L0 = 4'b0000;
    localparam logic [SEL_W-1:0] SEL_L1 = 4'b0001;
    localparam logic [SEL_W-1:0] SEL_L2 = 4'b0010;
    localparam logic [SEL_W-1:0] SEL_L3 = 4'b0100;
    localparam logic [SEL_W-1:0] SEL_L4 = 4'b1000;

    // One bit per operator button, shared by the synchronizer and edge-detect stages
    typedef struct packed {
        logic up;
        logic down;
        logic stop;
    } btn_t;

    // Select code for a level; anything outside 0..4 selects nothing
    function automatic logic [SEL_W-1:0] lvl2sel(input logic [LVL_W-1:0] level);
        logic [SEL_W-1:0] sel;
        case (level)
            LVL_STOP: sel = SEL_L0;
            LVL_1:    sel = SEL_L1;
            LVL_2:    sel = SEL_L2;
            LVL_3:    sel = SEL_L3;
            LVL_4:    sel = SEL_L4;
            default:  sel = SEL_L0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/moter_pwm_gen.sv
// PWM period counter and one duty waveform per speed level, registered and aligned with the counter.
module moter_pwm_gen #(
    parameter int unsigned PERIOD = 100_000,
    parameter int unsigned DUTY1  = 25,
    parameter int unsigned DUTY2  = 50,
    parameter int unsigned DUTY3  = 75,
    parameter int unsigned DUTY4  = 100
) (
    input  logic       clk,
    input  logic       rst,
    output logic [4:0] pwm_x,
    output logic       period_start,
    output logic       wrap_c
);

    localparam int unsigned CNT_W = (PERIOD > 4) ? $clog2(PERIOD) : 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    // Thresholds in 64-bit so PERIOD*DUTY cannot overflow before the divide
    localparam int unsigned T1 = 32'((64'(PERIOD) * 64'(DUTY1)) / 64'd100);
    localparam int unsigned T2 = 32'((64'(PERIOD) * 64'(DUTY2)) / 64'd100);
    localparam int unsigned T3 = 32'((64'(PERIOD) * 64'(DUTY3)) / 64'd100);
    localparam int unsigned T4 = 32'((64'(PERIOD) * 64'(DUTY4)) / 64'd100);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [4:0]       pwm_next;

    assign wrap_c = (cnt == CNT_LAST);

    // Next counter value and the waveforms it implies; level 0 never drives
    always_comb begin
        cnt_next    = wrap_c ? '0 : cnt + CNT_W'(1);
        pwm_next    = '0;
        pwm_next[1] = (32'(cnt_next) < T1);
        pwm_next[2] = (32'(cnt_next) < T2);
        pwm_next[3] = (32'(cnt_next) < T3);
        pwm_next[4] = (32'(cnt_next) < T4);
    end

    // Free-running counter with waveforms and period marker sampled from its next value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            pwm_x        <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            pwm_x        <= pwm_next;
            period_start <= (cnt_next == '0);
        end
    end

endmodule

// File: rtl/moter_speed_ctrl.sv
// Operator buttons to speed level, with the select code applied only at PWM period boundaries.
module moter_speed_ctrl
    import moter_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned PWM_HZ = 1_000,
    parameter int unsigned DUTY1  = 25,
    parameter int unsigned DUTY2  = 50,
    parameter int unsigned DUTY3  = 75,
    parameter int unsigned DUTY4  = 100
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_btn_stop,
    output logic [2:0] o_level,
    output logic [3:0] o_sel,
    output logic [4:0] o_pwm_x,
    output logic       o_period_start
);

    localparam int unsigned PERIOD = CLK_HZ / PWM_HZ;

    btn_t       btn_raw;
    btn_t       sync1;
    btn_t       sync2;
    btn_t       prev;
    btn_t       edge_q;
    logic [2:0] level_next;
    logic [2:0] up_lvl;
    logic [2:0] dn_lvl;
    logic       wrap_c;

    assign btn_raw = btn_t'({i_btn_up, i_btn_down, i_btn_stop});

    // Two-flop synchronizer, previous-value flop and registered rising-edge pulse
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1  <= '0;
            sync2  <= '0;
            prev   <= '0;
            edge_q <= '0;
        end else begin
            sync1  <= btn_raw;
            sync2  <= sync1;
            prev   <= sync2;
            edge_q <= btn_t'(sync2 & ~prev);
        end
    end

    // Level state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_level <= LVL_STOP;
        end else begin
            o_level <= level_next;
        end
    end

    // Next level: stop wins, up+down cancels, up/down saturate at the ends
    always_comb begin
        level_next = o_level;
        up_lvl     = LVL_STOP;
        dn_lvl     = LVL_STOP;
        case (o_level)
            LVL_STOP: begin up_lvl = LVL_1; dn_lvl = LVL_STOP; end
            LVL_1:    begin up_lvl = LVL_2; dn_lvl = LVL_STOP; end
            LVL_2:    begin up_lvl = LVL_3; dn_lvl = LVL_1;    end
            LVL_3:    begin up_lvl = LVL_4; dn_lvl = LVL_2;    end
            LVL_4:    begin up_lvl = LVL_4; dn_lvl = LVL_3;    end
            default:  begin up_lvl = LVL_STOP; dn_lvl = LVL_STOP; end
        endcase
        if (edge_q.stop) begin
            level_next = LVL_STOP;
        end else if (edge_q.up && edge_q.down) begin
            level_next = o_level;
        end else if (edge_q.up) begin
            level_next = up_lvl;
        end else if (edge_q.down) begin
            level_next = dn_lvl;
        end
    end

    // Select latch: takes the level being loaded on the wrap edge so no pulse is truncated
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_sel <= SEL_L0;
        end else if (wrap_c) begin
            o_sel <= lvl2sel(level_next);
        end
    end

    moter_pwm_gen #(
        .PERIOD (PERIOD),
        .DUTY1  (DUTY1),
        .DUTY2  (DUTY2),
        .DUTY3  (DUTY3),
        .DUTY4  (DUTY4)
    ) u_pwm_gen (
        .clk          (i_clk),
        .rst          (i_reset),
        .pwm_x        (o_pwm_x),
        .period_start (o_period_start),
        .wrap_c       (wrap_c)
    );

endmodule

// File: doc/moter_speed_ctrl.md
Name: moter_speed_ctrl

Overview:
Source side of the motor PWM select path: turns operator buttons into a speed level and drives the 5-bit PWM source vector (o_pwm_x) and 4-bit select code (o_sel) consumed by the motor mux. It owns the PWM period counter and derives one duty waveform per speed level. Select changes are applied only at PWM period boundaries so the motor output never sees a truncated pulse.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
PWM_HZ, 1_000, PWM frequency in Hz; PERIOD = CLK_HZ/PWM_HZ counts; PERIOD must be at least 4.
DUTY1, 25, duty of level 1 in percent (0..100)
DUTY2, 50, duty of level 2 in percent
DUTY3, 75, duty of level 3 in percent
DUTY4, 100, duty of level 4 in percent

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_btn_up  input  1  debounced level, asynchronous to i_clk; a rising edge requests the next level up
i_btn_down  input  1  debounced level, asynchronous; a rising edge requests the next level down
i_btn_stop  input  1  debounced level, asynchronous; a rising edge requests level 0
o_level  output  3  target speed level, 0..4
o_sel  output  4  applied select code: L0=0000, L1=0001, L2=0010, L3=0100, L4=1000
o_pwm_x  output  5  PWM sources; bit k is the waveform for level k
o_period_start  output  1  one-cycle pulse on the first cycle of each PWM period

Behaviour:
- Reset is asynchronous and active-high (i_reset). All registers clear on assertion: o_level=0, o_sel=0000, o_pwm_x=00000, o_period_start=0, counter=0, sync/edge flops=0.
- Each button passes through a 2-FF synchronizer, then a previous-value flop. The edge is synced & ~prev.
- Level update happens on the clock edge after the edge is detected. Latency from a button rising ahead of clock edge N to o_level changing at edge N+3.
- Priority within one cycle: stop > (up and down together: no change) > up > down.
- Up saturates at 4. Down saturates at 0. A saturated request is a silent no-op. Stop at level 0 is also a no-op.
- Held buttons produce no repeats; each press needs a fresh rising edge.
- Counter cnt runs 0..PERIOD-1 and wraps to 0. It is free-running from reset release.
- Threshold T_k = (PERIOD*DUTY_k)/100, with integer truncation, computed at elaboration. Use widths wide enough that the product does not overflow. T_0 = 0.
- o_pwm_x is registered. At each edge, o_pwm_x[k] <= (cnt_next < T_k), so it is aligned with cnt.
  - o_pwm_x[0] is always 0.
  - DUTY=100 gives a constant 1 after reset.
  - DUTY=0 gives a constant 0.
- o_period_start is registered and equals 1 in the cycle where the registered cnt is 0, except the first cycle after reset release.
- o_sel is the registered one-hot encoding of o_level, loaded only at the edge where cnt wraps from PERIOD-1 to 0. At that edge it samples the o_level value as of that edge, including any level update made on the same edge.
- If several level changes occur within one period, only the last level present at the wrap is applied. Intermediate levels never reach o_sel.
- Reset mid-period: everything clears immediately. Pending level changes are discarded.
- o_sel only ever takes the five legal codes. Default/invalid internal levels map to 0000.

Decomposition:
- Shared package moter_pkg holds the level constants LVL_STOP..LVL_4 (3-bit), the SEL_L0..SEL_L4 codes (4-bit), and a function lvl2sel(level) returning the code, or 0000 for illegal levels. The mux and this block both import it.
- Sub-module moter_pwm_gen holds the counter, T_k comparators, o_pwm_x and o_period_start, with PERIOD/DUTY parameters. The top level keeps the synchronizers, edge detect, level FSM and sel latch.

Test Plan:
Use CLK_HZ=1000 and PWM_HZ=100 (PERIOD=10, T=2/5/7/10) for all scenarios.
1. Reset: hold i_reset mid-run -> all outputs 0 immediately. After release, o_pwm_x[4]=1, o_pwm_x[3:1] follow cnt, and o_sel=0000.
2. Waveforms with no buttons -> per 10-cycle period, o_pwm_x[1] is high 2 cycles, [2] 5, [3] 7, [4] 10, [0] 0. o_period_start pulses every 10 cycles.
3. Up press once -> o_level=1 three edges after the press. o_sel=0001 only from the next wrap. Four more presses -> o_level stays 4 and o_sel=1000.
4. Within one period, press up, up, down (level 0->2->1) -> o_sel jumps 0000->0001 at the wrap, never 0010.
5. Simultaneous: up+down in the same cycle -> no change. Stop+up at level 3 -> o_level=0 and o_sel=0000 at the next wrap.
6. Hold up for 50 cycles -> a single increment. Assert reset mid-period with a pending change -> o_sel stays 0000 and o_level=0 after release.
